inst_rom_sync: RTL

INST_ROM_SYNC -- requirements
Module: inst_rom_sync

---
 rtl/inst_rom_sync_pkg.sv | 29 ++
 rtl/inst_rom_sync_mem_array.sv | 32 +++
 rtl/inst_rom_sync.sv | 130 +++++++++++++
 3 files changed

// File: rtl/inst_rom_sync_pkg.sv
// Shared constants, types and helpers for the instruction ROM block.
//   INST_MEM_NUM / INST_MEM_NUM_LOG2 : default instruction store depth and its log2
//   ADDR_BUS_W / DATA_BUS_W          : fetch address and instruction word widths
//   ZERO_WORD                        : value returned when no valid word is fetched
//   rom_state_e                      : BOOT / READY encoding of the ROM controller
package inst_rom_sync_pkg;

  localparam int INST_MEM_NUM      = 1024;
  localparam int INST_MEM_NUM_LOG2 = 10;
  localparam int ADDR_BUS_W        = 32;
  localparam int DATA_BUS_W        = 32;

  localparam logic [DATA_BUS_W-1:0] ZERO_WORD = '0;

  typedef enum logic {
    ST_BOOT  = 1'b0,
    ST_READY = 1'b1
  } rom_state_e;

  // A fetch is rejected if it is not word aligned or if it falls above the
  // last stored word (any address bit above the word index is set).
  function automatic logic is_bad_fetch(input logic [ADDR_BUS_W-1:0] addr,
                                        input int                    idx_w);
    logic [ADDR_BUS_W-1:0] upper;
    upper = addr >> (idx_w + 2);
    return (addr[1:0] != 2'b00) || (upper != '0);
  endfunction

endpackage

// File: rtl/inst_rom_sync_mem_array.sv
// Instruction storage: one synchronous write port, one synchronous read port,
// no reset (contents survive a controller reset).
//   i_clk    : clock
//   i_we     : write strobe, i_waddr / i_wdata written on the rising edge
//   i_re     : read strobe, o_rdata updated from i_raddr on the rising edge
//   o_rdata  : registered read data, holds its value when i_re is low
module inst_mem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 32
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      o_rdata <= r_mem[i_raddr];
    end
  end

endmodule

// File: rtl/inst_rom_sync.sv
// Loadable instruction ROM with a one-cycle synchronous fetch port.
// After reset the block sits in BOOT accepting the program image from a
// loader; once the loader signals completion it moves to READY and serves
// fetches from the core until the next reset.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_BOOT  | loader owns the store; core stalled, fetches ignored
//   ST_READY | image complete; core fetches, loader ignored
//
// Ports:
//   clock, reset        : clock and synchronous active-high reset
//   ce, address         : fetch request and byte address from the core
//   instruction         : fetched word (zero when no valid word)
//   inst_valid          : a fetch was taken on the previous edge
//   addr_err            : that fetch was misaligned or out of range
//   stall_req           : core must hold its PC (store still loading)
//   load_en, load_data  : loader write strobe and word
//   load_done           : loader has finished the image
//   load_count          : words written since reset, saturates at MEM_WORDS
module inst_rom_sync
  import inst_rom_sync_pkg::*;
#(
  parameter int MEM_WORDS = INST_MEM_NUM
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        ce,
  input  logic [ADDR_BUS_W-1:0]       address,
  output logic [DATA_BUS_W-1:0]       instruction,
  output logic                        inst_valid,
  output logic                        addr_err,
  output logic                        stall_req,
  input  logic                        load_en,
  input  logic [DATA_BUS_W-1:0]       load_data,
  input  logic                        load_done,
  output logic [$clog2(MEM_WORDS):0]  load_count
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(MEM_WORDS);

  rom_state_e r_state;
  rom_state_e w_state_nxt;

  logic [AW:0]           r_load_count;
  logic                  r_inst_valid;
  logic                  r_addr_err;
  logic                  r_fetch_ok;

  logic                  w_load_room;
  logic                  w_load_we;
  logic                  w_fetch;
  logic                  w_fetch_bad;
  logic                  w_read_en;
  logic [AW-1:0]         w_waddr;
  logic [AW-1:0]         w_raddr;
  logic [DATA_BUS_W-1:0] w_rdata;

  assign w_load_room = (r_load_count != FULL_COUNT);
  // Reset wins over a loader strobe arriving in the same cycle.
  assign w_load_we   = !reset && (r_state == ST_BOOT) && load_en && w_load_room;
  assign w_waddr     = r_load_count[AW-1:0];

  assign w_fetch     = (r_state == ST_READY) && ce;
  assign w_fetch_bad = is_bad_fetch(address, AW);
  assign w_raddr     = address[AW+1:2];
  // Rejected fetches never touch the array; the output is forced to zero anyway.
  assign w_read_en   = w_fetch && !w_fetch_bad;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BOOT:  if (load_done) w_state_nxt = ST_READY;
      ST_READY: w_state_nxt = ST_READY;
      default:  w_state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_load_count <= '0;
    end else if (w_load_we) begin
      r_load_count <= r_load_count + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_inst_valid <= 1'b0;
      r_addr_err   <= 1'b0;
      r_fetch_ok   <= 1'b0;
    end else begin
      r_inst_valid <= w_fetch;
      r_addr_err   <= w_fetch && w_fetch_bad;
      r_fetch_ok   <= w_read_en;
    end
  end

  inst_mem_array #(
    .DEPTH (MEM_WORDS),
    .AW    (AW),
    .DW    (DATA_BUS_W)
  ) u_mem (
    .i_clk   (clock),
    .i_we    (w_load_we),
    .i_waddr (w_waddr),
    .i_wdata (load_data),
    .i_re    (w_read_en),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // The array output is only meaningful after an accepted fetch; every other
  // cycle (reset, BOOT, idle, rejected address) presents the zero word.
  assign instruction = r_fetch_ok ? w_rdata : ZERO_WORD;
  assign inst_valid  = r_inst_valid;
  assign addr_err    = r_addr_err;
  assign stall_req   = (r_state == ST_BOOT);
  assign load_count  = r_load_count;

endmodule
